// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the fetch and MEM-stage data requesters.
// Latency: grant in cycle T -> mem_en in T+1 -> ack in T+2+LATENCY; back-to-back rate is one access per LATENCY+2 cycles.
// Backpressure: requesters hold req until their one-cycle ack; stall holds the pipeline while any request is unacked.
//
// Ports:
//   Clock, nReset               rising-edge clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_ack), byte address
//   if_rdata/if_ack             fetch read data, valid with the one-cycle if_ack pulse
//   d_req/d_we/d_be/d_addr/d_wdata  data request, write flag, byte enables, byte address, write data
//   d_rdata/d_ack               data read data, valid with the one-cycle d_ack pulse
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory command, driven for the single ISSUE cycle
//   mem_rdata                   memory read data, valid LATENCY cycles after mem_en
//   stall                       combinational pipeline hold
module mem_port_arbiter #(
  parameter int LATENCY        = 1,  // 1..15
  parameter int MAX_DATA_BURST = 4   // 1..15
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] MAX_BURST = 4'(MAX_DATA_BURST);
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic [3:0]  wait_q, wait_d;
  logic        fetch_q, fetch_d;    // granted access belongs to the fetch port
  logic        cmd_we_q, cmd_we_d;  // granted access is a write
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // Byte-lane bits of the request addresses are dropped; memory is word addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    fetch_d     = fetch_q;
    cmd_we_d    = cmd_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE, RESP: begin
        // Arbitrate on this cycle's requests; in RESP this overlaps the ack.
        if (d_req && (!if_req || (burst_q < MAX_BURST))) begin
          state_d    = ISSUE;
          fetch_d    = 1'b0;
          cmd_we_d   = d_we;
          mem_en_d   = 1'b1;
          mem_we_d   = d_we;
          mem_be_d   = d_we ? d_be : 4'b1111;
          mem_addr_d = {d_addr[31:2], 2'b00};
          if (d_we) begin
            mem_wdata_d = d_wdata;
          end
          // The grant condition keeps burst_q below MAX_BURST here, so +1 saturates at the limit.
          burst_d = if_req ? (burst_q + 4'd1) : 4'd0;
        end else if (if_req) begin
          state_d    = ISSUE;
          fetch_d    = 1'b1;
          cmd_we_d   = 1'b0;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = 4'b1111;
          mem_addr_d = {if_addr[31:2], 2'b00};
          burst_d    = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          // Last WAIT cycle: mem_rdata is valid now, capture it alongside the ack.
          state_d = RESP;
          if (fetch_q) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!cmd_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      burst_q     <= 4'd0;
      wait_q      <= 4'd0;
      fetch_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      fetch_q     <= fetch_d;
      cmd_we_q    <= cmd_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // The pipeline is itself in reset while nReset is low, so it must not see a hold then.
  assign stall = nReset && ((d_req && !d_ack_q) || (if_req && !if_ack_q));

endmodule
